// File: rtl/led_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// led_pulse_stretcher
//
// Turns single-cycle event pulses into human-visible LED blinks. Every event
// produces one blink: ON for ON_TICKS ticks, then a dark gap of OFF_TICKS
// ticks. Events that arrive while a channel is already blinking are queued
// (up to PENDING_MAX per channel) and replayed back to back. Events beyond the
// queue limit are dropped and flagged with a one-cycle overflow pulse.
//
// A single free-running tick generator (period TICK_CNT_MAX clocks) paces all
// channels. Apart from that shared tick, channels are fully independent.
//
// Ports (top, led_pulse_stretcher):
//   clk       in   1             system clock, rising edge
//   rst       in   1             asynchronous active-high reset
//   pulse_in  in   SIGNAL_WIDTH  per-channel event, each high cycle = 1 event
//   led_out   out  SIGNAL_WIDTH  per-channel LED drive, high while ON
//   busy      out  SIGNAL_WIDTH  per-channel, high whenever not IDLE
//   overflow  out  SIGNAL_WIDTH  per-channel one-cycle pulse on a dropped event
//
// Ports (led_pulse_stretcher_channel, one per bit):
//   clk, rst  in   1   as above
//   tick      in   1   shared timing tick, one cycle wide
//   pulse     in   1   event for this channel
//   led       out  1   LED drive
//   busy      out  1   channel active
//   overflow  out  1   registered drop indication
// ---------------------------------------------------------------------------

module led_pulse_stretcher_channel #(
  parameter int ON_TICKS    = 200,
  parameter int OFF_TICKS   = 200,
  parameter int PENDING_MAX = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pulse,
  output logic led,
  output logic busy,
  output logic overflow
);

  // The phase counter only needs to reach the larger of the two phase lengths
  // minus one; keep at least one bit so degenerate lengths still elaborate.
  localparam int PHASE_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int NW        = $clog2(PENDING_MAX + 1);

  localparam logic [PW-1:0] ON_LAST   = PW'(ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_TICKS - 1);
  localparam logic [NW-1:0] PEND_FULL = NW'(PENDING_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic [NW-1:0] pending;
  logic [NW-1:0] pending_nxt;
  logic          overflow_nxt;

  logic          on_done;
  logic          off_done;
  logic          queue_full;

  // Terminal-tick detection for each timed phase.
  assign on_done    = tick && (phase == ON_LAST);
  assign off_done   = tick && (phase == OFF_LAST);
  assign queue_full = (pending == PEND_FULL);

  // State register. Reset aborts any blink in progress and drops the queue;
  // overflow is registered so it appears the cycle after the dropped event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Next-state logic. The OFF terminal tick looks at "effective pending"
  // (queued events plus an event arriving this very cycle), so a pulse that
  // lands exactly on that tick starts the next blink instead of being lost,
  // and a pulse coinciding with a queue pop leaves the count unchanged.
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    pending_nxt  = pending;
    overflow_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        // The event is consumed directly by starting the blink.
        if (pulse) begin
          state_nxt = ST_ON;
          phase_nxt = '0;
        end
      end

      ST_ON: begin
        if (on_done) begin
          state_nxt = ST_OFF;
          phase_nxt = '0;
        end else if (tick) begin
          phase_nxt = phase + PW'(1);
        end

        if (pulse) begin
          if (queue_full) begin
            overflow_nxt = 1'b1;
          end else begin
            pending_nxt = pending + NW'(1);
          end
        end
      end

      ST_OFF: begin
        if (off_done) begin
          phase_nxt = '0;
          if ((pending != '0) || pulse) begin
            state_nxt = ST_ON;
            // A fresh pulse replaces the popped entry, so only decrement
            // when nothing new arrived.
            if (!pulse) begin
              pending_nxt = pending - NW'(1);
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          if (tick) begin
            phase_nxt = phase + PW'(1);
          end

          if (pulse) begin
            if (queue_full) begin
              overflow_nxt = 1'b1;
            end else begin
              pending_nxt = pending + NW'(1);
            end
          end
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        phase_nxt   = '0;
        pending_nxt = '0;
      end
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    led  = (state == ST_ON);
    busy = (state != ST_IDLE);
  end

endmodule


module led_pulse_stretcher #(
  parameter int SIGNAL_WIDTH = 1,
  parameter int TICK_CNT_MAX = 62500,
  parameter int ON_TICKS     = 200,
  parameter int OFF_TICKS    = 200,
  parameter int PENDING_MAX  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIGNAL_WIDTH-1:0] pulse_in,
  output logic [SIGNAL_WIDTH-1:0] led_out,
  output logic [SIGNAL_WIDTH-1:0] busy,
  output logic [SIGNAL_WIDTH-1:0] overflow
);

  // With TICK_CNT_MAX == 1 the counter sits at zero and tick is constantly
  // high; one bit is kept so the register still exists.
  localparam int TW = (TICK_CNT_MAX > 1) ? $clog2(TICK_CNT_MAX) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT_MAX - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  // Shared free-running tick generator. Starting at zero after reset puts
  // the first tick in the TICK_CNT_MAX-th cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  for (genvar i = 0; i < SIGNAL_WIDTH; i++) begin : g_chan
    led_pulse_stretcher_channel #(
      .ON_TICKS    (ON_TICKS),
      .OFF_TICKS   (OFF_TICKS),
      .PENDING_MAX (PENDING_MAX)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .pulse    (pulse_in[i]),
      .led      (led_out[i]),
      .busy     (busy[i]),
      .overflow (overflow[i])
    );
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// tb_led_pulse_stretcher
//
// Self-checking bench for led_pulse_stretcher with two channels, a 4-cycle
// tick, 2 ON ticks, 1 OFF tick and a queue depth of 2. Each directed step
// pushes the blinks it should cause onto a per-channel queue; a sampler run
// every falling clock edge measures each finished blink (ON length, dark gap,
// and whether the channel then went idle) and pops the matching entry.
// ---------------------------------------------------------------------------

module tb_led_pulse_stretcher;

  localparam int W     = 2;
  localparam int T     = 4;
  localparam int ON_T  = 2;
  localparam int OFF_T = 1;
  localparam int PMAX  = 2;

  // A first blink starts at an arbitrary point between ticks; blinks that
  // follow an OFF phase start right after a tick and therefore run full.
  localparam int ON_MIN  = (ON_T - 1) * T + 1;
  localparam int ON_FULL = ON_T * T;
  localparam int GAP     = OFF_T * T;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pulse_in;
  logic [W-1:0] led_out;
  logic [W-1:0] busy;
  logic [W-1:0] overflow;

  led_pulse_stretcher #(
    .SIGNAL_WIDTH (W),
    .TICK_CNT_MAX (T),
    .ON_TICKS     (ON_T),
    .OFF_TICKS    (OFF_T),
    .PENDING_MAX  (PMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int on_min;
    int on_max;
    int gap;
    bit ends_idle;
  } blink_t;

  blink_t exp_q0[$];
  blink_t exp_q1[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit in_on    [W];
  bit in_gap   [W];
  int on_cnt   [W];
  int gap_cnt  [W];
  int last_on  [W];
  int ovf_seen [W];
  int led_seen [W];
  int fall_cyc [W];

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_range(input string tag, input int observed,
                             input int lo, input int hi);
    checks++;
    assert (observed >= lo && observed <= hi) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
    end
  endtask

  task automatic expect_blink(input int ch, input int lo, input int hi,
                              input bit ends_idle);
    blink_t b;
    b.on_min    = lo;
    b.on_max    = hi;
    b.gap       = GAP;
    b.ends_idle = ends_idle;
    if (ch == 0) exp_q0.push_back(b);
    else         exp_q1.push_back(b);
  endtask

  task automatic finish_blink(input int ch, input bit idle_obs);
    blink_t e;
    bit     have;
    have = 1'b0;
    if (ch == 0 && exp_q0.size() > 0) begin
      e    = exp_q0.pop_front();
      have = 1'b1;
    end else if (ch == 1 && exp_q1.size() > 0) begin
      e    = exp_q1.pop_front();
      have = 1'b1;
    end
    check_output($sformatf("ch%0d blink was expected", ch), 32'(have), 1);
    if (have) begin
      check_range($sformatf("ch%0d on length", ch), last_on[ch], e.on_min, e.on_max);
      check_output($sformatf("ch%0d gap length", ch), gap_cnt[ch], e.gap);
      check_output($sformatf("ch%0d idle after gap", ch), 32'(idle_obs), 32'(e.ends_idle));
    end
  endtask

  task automatic monitor_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int ch = 0; ch < W; ch++) begin
      in_on[ch]    = 1'b0;
      in_gap[ch]   = 1'b0;
      on_cnt[ch]   = 0;
      gap_cnt[ch]  = 0;
      last_on[ch]  = 0;
      ovf_seen[ch] = 0;
      led_seen[ch] = 0;
      fall_cyc[ch] = 0;
    end
  endtask

  // Blink measurement: a blink closes either when the LED comes back on
  // (busy held through the gap) or when busy drops.
  task automatic monitor_sample();
    for (int ch = 0; ch < W; ch++) begin
      if (overflow[ch] === 1'b1) ovf_seen[ch]++;
      if (led_out[ch] === 1'b1) begin
        led_seen[ch]++;
        if (in_gap[ch]) begin
          in_gap[ch] = 1'b0;
          finish_blink(ch, 1'b0);
        end
        if (!in_on[ch]) begin
          in_on[ch]  = 1'b1;
          on_cnt[ch] = 0;
        end
        on_cnt[ch]++;
      end else begin
        if (in_on[ch]) begin
          in_on[ch]    = 1'b0;
          in_gap[ch]   = 1'b1;
          gap_cnt[ch]  = 0;
          last_on[ch]  = on_cnt[ch];
          fall_cyc[ch] = cyc;
        end
        if (in_gap[ch]) begin
          if (busy[ch] === 1'b1) begin
            gap_cnt[ch]++;
          end else begin
            in_gap[ch] = 1'b0;
            finish_blink(ch, 1'b1);
          end
        end
      end
    end
  endtask

  // One clock cycle: sample outputs on the falling edge, then drive the
  // pulse pattern seen by the next rising edge.
  task automatic apply_stimulus(input logic [W-1:0] p);
    @(negedge clk);
    cyc++;
    monitor_sample();
    pulse_in = p;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      apply_stimulus('0);
      n++;
    end while (busy !== '0 && n < budget);
    check_output({tag, " reached idle"}, 32'(busy), 0);
  endtask

  // Leaves the bench at the first falling edge of an OFF phase on ch0.
  task automatic wait_led_fall(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      apply_stimulus('0);
      n++;
    end while (!in_gap[0] && n < budget);
    check_output({tag, " led fall seen"}, 32'(in_gap[0]), 1);
  endtask

  task automatic check_queues_empty(input string tag);
    check_output({tag, " ch0 blinks outstanding"}, exp_q0.size(), 0);
    check_output({tag, " ch1 blinks outstanding"}, exp_q1.size(), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b1;
    pulse_in = '0;
    monitor_reset();

    // Reset and idle hold.
    repeat (3) @(negedge clk);
    check_output("reset led_out", 32'(led_out), 0);
    check_output("reset busy", 32'(busy), 0);
    check_output("reset overflow", 32'(overflow), 0);
    rst = 1'b0;
    repeat (20) apply_stimulus('0);
    check_output("idle led_out", 32'(led_out), 0);
    check_output("idle busy", 32'(busy), 0);
    check_output("idle led samples", led_seen[0] + led_seen[1], 0);

    // Single event on ch0.
    $display("[TB] single event");
    monitor_reset();
    expect_blink(0, ON_MIN, ON_FULL, 1'b1);
    apply_stimulus(2'b01);
    apply_stimulus(2'b00);
    check_output("single led next cycle", 32'(led_out), 1);
    check_output("single busy", 32'(busy), 1);
    wait_idle("single", 40);
    check_queues_empty("single");
    check_output("single ch1 led samples", led_seen[1], 0);
    check_output("single overflow count", ovf_seen[0], 0);

    // Three events: one starts the blink, two are queued.
    $display("[TB] queue of three");
    monitor_reset();
    expect_blink(0, ON_MIN, ON_FULL, 1'b0);
    expect_blink(0, ON_FULL, ON_FULL, 1'b0);
    expect_blink(0, ON_FULL, ON_FULL, 1'b1);
    apply_stimulus(2'b01);
    apply_stimulus(2'b00);
    apply_stimulus(2'b01);
    apply_stimulus(2'b00);
    apply_stimulus(2'b01);
    apply_stimulus(2'b00);
    wait_idle("queue", 80);
    check_queues_empty("queue");
    check_output("queue overflow count", ovf_seen[0], 0);

    // Four back-to-back events: the fourth is dropped.
    $display("[TB] overflow");
    monitor_reset();
    expect_blink(0, ON_MIN, ON_FULL, 1'b0);
    expect_blink(0, ON_FULL, ON_FULL, 1'b0);
    expect_blink(0, ON_FULL, ON_FULL, 1'b1);
    repeat (4) apply_stimulus(2'b01);
    apply_stimulus(2'b00);
    check_output("overflow after 4th pulse", 32'(overflow), 1);
    apply_stimulus(2'b00);
    check_output("overflow one cycle wide", 32'(overflow), 0);
    wait_idle("overflow", 80);
    check_queues_empty("overflow");
    check_output("overflow count", ovf_seen[0], 1);

    // Pulse on the terminal OFF tick while one event is already queued.
    $display("[TB] terminal tick with pending=1");
    monitor_reset();
    expect_blink(0, ON_MIN, ON_FULL, 1'b0);
    expect_blink(0, ON_FULL, ON_FULL, 1'b0);
    expect_blink(0, ON_FULL, ON_FULL, 1'b1);
    apply_stimulus(2'b01);
    apply_stimulus(2'b00);
    apply_stimulus(2'b01);
    wait_led_fall("sim1", 20);
    apply_stimulus(2'b00);
    apply_stimulus(2'b00);
    apply_stimulus(2'b01);
    wait_idle("sim1", 80);
    check_queues_empty("sim1");
    check_output("sim1 overflow count", ovf_seen[0], 0);

    // Pulse on the terminal OFF tick with nothing queued.
    $display("[TB] terminal tick with pending=0");
    monitor_reset();
    expect_blink(0, ON_MIN, ON_FULL, 1'b0);
    expect_blink(0, ON_FULL, ON_FULL, 1'b1);
    apply_stimulus(2'b01);
    wait_led_fall("sim0", 20);
    apply_stimulus(2'b00);
    apply_stimulus(2'b00);
    apply_stimulus(2'b01);
    wait_idle("sim0", 60);
    check_queues_empty("sim0");

    // Staggered events on both channels.
    $display("[TB] independence");
    monitor_reset();
    expect_blink(0, ON_MIN, ON_FULL, 1'b1);
    expect_blink(1, ON_MIN, ON_FULL, 1'b1);
    apply_stimulus(2'b01);
    apply_stimulus(2'b00);
    check_output("indep ch0 only", 32'(led_out), 1);
    apply_stimulus(2'b00);
    apply_stimulus(2'b10);
    apply_stimulus(2'b00);
    check_output("indep both lit", 32'(led_out), 3);
    wait_idle("indep", 60);
    check_queues_empty("indep");
    check_output("indep falls on shared ticks", (fall_cyc[1] - fall_cyc[0]) % T, 0);

    // Asynchronous reset mid-ON, with an overflow pulse showing.
    $display("[TB] async reset mid-blink");
    monitor_reset();
    repeat (4) apply_stimulus(2'b01);
    apply_stimulus(2'b00);
    check_output("pre-reset led", 32'(led_out), 1);
    check_output("pre-reset overflow", 32'(overflow), 1);
    #2;
    rst = 1'b1;
    #1;
    check_output("async reset led_out", 32'(led_out), 0);
    check_output("async reset busy", 32'(busy), 0);
    check_output("async reset overflow", 32'(overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    monitor_reset();
    repeat (30) apply_stimulus('0);
    check_output("post-reset led samples", led_seen[0] + led_seen[1], 0);
    check_output("post-reset busy", 32'(busy), 0);
    expect_blink(0, ON_MIN, ON_FULL, 1'b1);
    apply_stimulus(2'b01);
    apply_stimulus(2'b00);
    wait_idle("post-reset", 40);
    check_queues_empty("post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pulse_stretcher.md
Name: led_pulse_stretcher

Overview:
- Output-side counterpart of the button input chain. Takes single-cycle event pulses and turns each one into a human-visible LED blink of fixed on and off length.
- Queues events that arrive while a channel is already blinking, so N events always give N distinct blinks, up to a saturation limit.
- Sits between control logic and board LED pins; one independent channel per bit.

Parameters:
- SIGNAL_WIDTH, 1: number of independent channels.
- TICK_CNT_MAX, 62500: clock cycles per timing tick (shared free-running tick generator); must be ≥1.
- ON_TICKS, 200: ticks the LED stays lit per blink; must be ≥1.
- OFF_TICKS, 200: ticks of dark gap after each blink; must be ≥1.
- PENDING_MAX, 7: maximum queued events per channel; must be ≥1.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- pulse_in, input, SIGNAL_WIDTH: per-channel event pulse, synchronous to clk; each high cycle counts as one event.
- led_out, output, SIGNAL_WIDTH: per-channel LED drive, high while the channel is in ON.
- busy, output, SIGNAL_WIDTH: per-channel, high whenever the channel is not IDLE.
- overflow, output, SIGNAL_WIDTH: per-channel one-cycle pulse when an event is dropped because the queue is full.

Behaviour:
- Reset: asynchronous, active-high.
  - All state returns to IDLE; pending=0, phase=0, tick counter=0.
  - led_out, busy and overflow are 0 immediately on rst assertion, with no clock needed.
  - Reset mid-blink aborts the blink and discards the queue.
- Tick generator:
  - Single counter shared by all channels, counting 0..TICK_CNT_MAX-1 and wrapping.
  - tick=1 for the one cycle when count==TICK_CNT_MAX-1.
  - TICK_CNT_MAX=1 gives tick every cycle.
  - First tick falls in the TICK_CNT_MAX-th cycle after reset release.
- Per-channel FSM: states IDLE, ON, OFF. Each channel has a phase counter (ticks elapsed in the current state) and a pending counter of width clog2(PENDING_MAX+1).
- IDLE:
  - pulse_in=1 → ON on the next edge, phase=0; the event is consumed directly and pending is unchanged.
  - led_out rises one cycle after the pulse cycle.
- ON:
  - On tick, phase increments.
  - On tick with phase==ON_TICKS-1 → OFF, phase=0.
- OFF:
  - On tick, phase increments.
  - On tick with phase==OFF_TICKS-1 and effective pending>0 → ON, pending decremented, phase=0.
  - On the same terminal tick with effective pending==0 → IDLE.
- Effective pending = registered pending plus any pulse_in in the current cycle.
- Queueing: pulse_in=1 while in ON or OFF:
  - pending<PENDING_MAX: pending+1.
  - pending==PENDING_MAX: pending unchanged, overflow=1 next cycle for one cycle.
- Simultaneous events:
  - Pulse in the same cycle as an OFF→ON pending decrement: net pending unchanged, no overflow.
  - Pulse on the terminal OFF tick with pending==0: goes ON (not IDLE); pending stays 0.
- Blink durations (T=TICK_CNT_MAX, ticks unaligned to events):
  - ON lasts (ON_TICKS-1)·T+1 to ON_TICKS·T cycles.
  - Each OFF lasts exactly OFF_TICKS·T cycles.
- Registered outputs:
  - busy is combinational from the state register.
  - led_out is combinational from the state register: high iff ON.
  - overflow is a registered pulse.
- Channels share only the tick generator; otherwise fully independent.

Test Plan:
Common parameters: SIGNAL_WIDTH=2, TICK_CNT_MAX=4, ON_TICKS=2, OFF_TICKS=1, PENDING_MAX=2.
- Reset: apply rst, then hold idle 20 cycles → led_out=busy=overflow=0. Assert rst asynchronously mid-ON (between edges) → led_out=0 immediately; after release, no further blinks.
- Single event: one-cycle pulse_in[0] → led_out[0] high from next cycle for 5..8 cycles, then low 4 cycles. busy[0] high through both phases, then 0. Channel 1 stays 0.
- Queue: three pulses on ch0 during first ON → exactly 3 blinks, each separated by a 4-cycle gap. busy stays high across all; overflow never asserted.
- Overflow: four pulses on ch0 during first ON → one-cycle overflow[0] after the 4th pulse; exactly 3 blinks total.
- Simultaneous: pulse on ch0 in the exact cycle of the terminal OFF tick, with pending=1 → next blink starts and pending remains 1, giving 2 further blinks total. Separately, with pending=0 → blink starts, channel does not pass through IDLE (busy stays 1).
- Independence: staggered pulses on ch0 and ch1 → each channel's led/busy timing matches its single-channel result; blinks are bounded by the same tick edges.
